// File: rtl/sprite_motion_engine.sv
// sprite_motion_engine: moves NUM_SPR sprites by signed velocities every UPDATE_DIV frames, bouncing or wrapping in a MAX_X x MAX_Y field
//   i_pix_clk/i_reset_n : pixel clock, async active-low reset
//   i_vert_sync         : vsync, rising edge is the frame tick
//   i_enable            : freezes the frame counter when low
//   i_wrap_mode         : 0 bounce, 1 wrap
//   i_load_*/o_load_ready : host load of one sprite's position and velocity (IDLE only)
//   o_pos_x/o_pos_y     : packed positions, sprite k at [k*COORD_W +: COORD_W]
//   o_busy/o_update_done : pass in progress / one-cycle end-of-pass pulse
module sprite_motion_engine #(
    parameter int NUM_SPR    = 4,
    parameter int COORD_W    = 16,
    parameter int MAX_X      = 800,
    parameter int MAX_Y      = 150,
    parameter int UPDATE_DIV = 8,
    parameter int INIT_VX    = 8,
    parameter int INIT_VY    = 0,
    localparam int SEL_W     = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1,
    localparam int CNT_W     = (UPDATE_DIV > 1) ? $clog2(UPDATE_DIV) : 1
) (
    input  logic                       i_pix_clk,
    input  logic                       i_reset_n,
    input  logic                       i_vert_sync,
    input  logic                       i_enable,
    input  logic                       i_wrap_mode,
    input  logic                       i_load_valid,
    output logic                       o_load_ready,
    input  logic [SEL_W-1:0]           i_load_sel,
    input  logic [COORD_W-1:0]         i_load_x,
    input  logic [COORD_W-1:0]         i_load_y,
    input  logic [COORD_W-1:0]         i_load_vx,
    input  logic [COORD_W-1:0]         i_load_vy,
    output logic [NUM_SPR*COORD_W-1:0] o_pos_x,
    output logic [NUM_SPR*COORD_W-1:0] o_pos_y,
    output logic                       o_busy,
    output logic                       o_update_done
);
    typedef enum logic [1:0] {IDLE, UPDATE, DONE} state_t;

    localparam logic signed [COORD_W:0] MX   = (COORD_W+1)'(MAX_X);
    localparam logic signed [COORD_W:0] MY   = (COORD_W+1)'(MAX_Y);
    localparam logic [SEL_W-1:0]        LAST = SEL_W'(NUM_SPR - 1);

    // Returns {new_p, new_v}; the sum is formed one bit wider so it cannot overflow.
    function automatic logic [2*COORD_W-1:0] step(
        input logic signed [COORD_W-1:0] p,
        input logic signed [COORD_W-1:0] v,
        input logic signed [COORD_W:0]   m,
        input logic                      wrap
    );
        logic signed [COORD_W:0]   n;
        logic signed [COORD_W-1:0] nv;
        n  = {p[COORD_W-1], p} + {v[COORD_W-1], v};
        // The most negative velocity has no positive counterpart, so it saturates.
        nv = (v == {1'b1, {(COORD_W-1){1'b0}}}) ? {1'b0, {(COORD_W-1){1'b1}}} : -v;
        if (wrap)
            return {(n >= m) ? COORD_W'(n - m) : n[COORD_W] ? COORD_W'(n + m) : n[COORD_W-1:0], v};
        return (n >= m) ? {COORD_W'(m - 1), nv} : n[COORD_W] ? {{COORD_W{1'b0}}, nv} : {n[COORD_W-1:0], v};
    endfunction

    state_t                    state, state_nx;
    logic [SEL_W-1:0]          ch, ch_nx;
    logic [CNT_W-1:0]          frame_cnt;
    logic                      s1, s2, s3, tick, trig, load_go, upd;
    logic [2*COORD_W-1:0]      nx, ny;
    logic signed [COORD_W-1:0] px [NUM_SPR];
    logic signed [COORD_W-1:0] py [NUM_SPR];
    logic signed [COORD_W-1:0] vx [NUM_SPR];
    logic signed [COORD_W-1:0] vy [NUM_SPR];

    // s1/s2 synchronise vsync, s3 holds the previous synchronised level for edge detection.
    assign tick         = s2 & ~s3;
    assign trig         = tick & i_enable & (frame_cnt == CNT_W'(UPDATE_DIV - 1));
    assign o_load_ready = state == IDLE;
    assign load_go      = i_load_valid & o_load_ready;
    assign upd          = state == UPDATE;

    always_ff @(posedge i_pix_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            {s1, s2, s3} <= '0;
            frame_cnt    <= '0;
            state        <= IDLE;
            ch           <= '0;
        end else begin
            {s1, s2, s3} <= {i_vert_sync, s1, s2};
            if (tick && i_enable)
                frame_cnt <= trig ? '0 : frame_cnt + 1'b1;
            state <= state_nx;
            ch    <= ch_nx;
        end
    end

    // A trigger arriving outside IDLE is simply ignored.
    always_comb begin
        state_nx      = state;
        ch_nx         = ch;
        o_busy        = state != IDLE;
        o_update_done = state == DONE;
        case (state)
            IDLE:    begin state_nx = trig ? UPDATE : IDLE; ch_nx = '0; end
            UPDATE:  begin state_nx = (ch == LAST) ? DONE : UPDATE; ch_nx = (ch == LAST) ? ch : ch + 1'b1; end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        nx = step(px[ch], vx[ch], MX, i_wrap_mode);
        ny = step(py[ch], vy[ch], MY, i_wrap_mode);
    end

    // Loads only happen in IDLE and updates only in UPDATE, so the two never collide.
    // An out-of-range i_load_sel matches no channel and is dropped.
    always_ff @(posedge i_pix_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int k = 0; k < NUM_SPR; k++) begin
                px[k] <= '0;
                py[k] <= '0;
                vx[k] <= COORD_W'(INIT_VX);
                vy[k] <= COORD_W'(INIT_VY);
            end
        end else begin
            for (int k = 0; k < NUM_SPR; k++) begin
                if (load_go && 32'(i_load_sel) == k) begin
                    px[k] <= i_load_x;
                    py[k] <= i_load_y;
                    vx[k] <= i_load_vx;
                    vy[k] <= i_load_vy;
                end else if (upd && 32'(ch) == k) begin
                    {px[k], vx[k]} <= nx;
                    {py[k], vy[k]} <= ny;
                end
            end
        end
    end

    for (genvar k = 0; k < NUM_SPR; k++) begin : g_pack
        assign o_pos_x[k*COORD_W +: COORD_W] = px[k];
        assign o_pos_y[k*COORD_W +: COORD_W] = py[k];
    end
endmodule

// File: tb/tb_sprite_motion_engine.sv
// tb_sprite_motion_engine: directed checks of sprite_motion_engine motion, loads and control edges
module tb_sprite_motion_engine;
    logic        clk = 0, rst_n = 0;
    logic        i_vert_sync = 0, i_enable = 1, i_wrap_mode = 0, i_load_valid = 0;
    logic [1:0]  i_load_sel = '0;
    logic [15:0] i_load_x = '0, i_load_y = '0, i_load_vx = '0, i_load_vy = '0;
    logic        o_load_ready, o_busy, o_update_done;
    logic [63:0] o_pos_x, o_pos_y;
    int          compared = 0, mismatched = 0, done_cnt = 0, busy_cnt = 0;

    sprite_motion_engine dut (
        .i_pix_clk(clk), .i_reset_n(rst_n), .i_vert_sync(i_vert_sync), .i_enable(i_enable),
        .i_wrap_mode(i_wrap_mode), .i_load_valid(i_load_valid), .o_load_ready(o_load_ready),
        .i_load_sel(i_load_sel), .i_load_x(i_load_x), .i_load_y(i_load_y), .i_load_vx(i_load_vx),
        .i_load_vy(i_load_vy), .o_pos_x(o_pos_x), .o_pos_y(o_pos_y), .o_busy(o_busy),
        .o_update_done(o_update_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (o_update_done) done_cnt <= done_cnt + 1;
        if (o_busy) busy_cnt <= busy_cnt + 1;
    end

    function automatic int sx(int k);
        logic signed [15:0] v;
        v = o_pos_x[k*16 +: 16];
        return int'(v);
    endfunction

    function automatic int sy(int k);
        logic signed [15:0] v;
        v = o_pos_y[k*16 +: 16];
        return int'(v);
    endfunction

    task automatic chk(string tag, int obs, int exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic ticks(int n);
        for (int i = 0; i < n; i++) begin
            i_vert_sync = 1;
            repeat (6) @(negedge clk);
            i_vert_sync = 0;
            repeat (10) @(negedge clk);
        end
    endtask

    task automatic set_load(int sel, int x, int y, int vx, int vy);
        i_load_sel = 2'(sel);
        i_load_x = 16'(x);
        i_load_y = 16'(y);
        i_load_vx = 16'(vx);
        i_load_vy = 16'(vy);
        i_load_valid = 1;
    endtask

    task automatic load(int sel, int x, int y, int vx, int vy);
        @(negedge clk);
        set_load(sel, x, y, vx, vy);
        @(negedge clk);
        i_load_valid = 0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        for (int k = 0; k < 4; k++) chk("rst_x", sx(k), 0);
        chk("rst_y0", sy(0), 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_update_done, 0);
        chk("rst_ready", o_load_ready, 1);
        rst_n = 1;

        ticks(7);
        chk("div7_x0", sx(0), 0);
        chk("div7_done", done_cnt, 0);
        ticks(1);
        for (int k = 0; k < 4; k++) chk("div8_x", sx(k), 8);
        chk("div8_y0", sy(0), 0);
        chk("div8_done", done_cnt, 1);
        chk("div8_busy", busy_cnt, 5);

        load(0, 796, 0, 8, 0);
        chk("load_x0", sx(0), 796);
        ticks(8);
        chk("bounce_r1", sx(0), 799);
        ticks(8);
        chk("bounce_r2", sx(0), 791);
        chk("bounce_r_x1", sx(1), 24);

        load(1, 100, 3, 0, -5);
        ticks(8);
        chk("bounce_t1", sy(1), 0);
        ticks(8);
        chk("bounce_t2", sy(1), 5);
        chk("bounce_t_x1", sx(1), 100);

        i_wrap_mode = 1;
        load(2, 796, 0, 8, 0);
        ticks(8);
        chk("wrap_r", sx(2), 4);
        load(2, 2, 0, -8, 0);
        ticks(8);
        chk("wrap_l", sx(2), 794);
        ticks(8);
        chk("wrap_l2", sx(2), 786);
        chk("wrap_x3", sx(3), 64);
        chk("wrap_y1", sy(1), 20);

        ticks(7);
        i_vert_sync = 1;
        @(negedge clk);
        @(negedge clk);
        chk("coll_idle", o_busy, 0);
        set_load(3, 10, 0, 3, 0);
        @(negedge clk);
        i_load_valid = 0;
        chk("coll_busy", o_busy, 1);
        repeat (5) @(negedge clk);
        i_vert_sync = 0;
        repeat (10) @(negedge clk);
        chk("coll_x3", sx(3), 13);
        chk("coll_x2", sx(2), 778);
        chk("coll_done", done_cnt, 9);

        ticks(7);
        i_vert_sync = 1;
        repeat (3) @(negedge clk);
        set_load(0, 200, 0, 0, 0);
        chk("hold_ready", o_load_ready, 0);
        for (int i = 0; i < 12 && !o_load_ready; i++) @(negedge clk);
        chk("hold_ready_back", o_load_ready, 1);
        @(negedge clk);
        i_load_valid = 0;
        chk("hold_x0", sx(0), 200);
        i_vert_sync = 0;
        repeat (10) @(negedge clk);
        chk("hold_x3", sx(3), 16);
        chk("hold_y1", sy(1), 30);

        i_enable = 0;
        ticks(20);
        chk("en0_x3", sx(3), 16);
        chk("en0_done", done_cnt, 10);
        i_enable = 1;
        ticks(7);
        chk("en1_7_x3", sx(3), 16);
        ticks(1);
        chk("en1_8_x3", sx(3), 19);
        chk("en1_8_y1", sy(1), 35);
        chk("en1_8_x0", sx(0), 200);
        chk("en1_8_done", done_cnt, 11);

        ticks(7);
        i_vert_sync = 1;
        repeat (3) @(negedge clk);
        chk("mid_busy", o_busy, 1);
        #2 rst_n = 0;
        #1;
        chk("mid_rst_x3", sx(3), 0);
        chk("mid_rst_x0", sx(0), 0);
        chk("mid_rst_y1", sy(1), 0);
        chk("mid_rst_busy", o_busy, 0);
        chk("mid_rst_ready", o_load_ready, 1);
        chk("mid_rst_done", o_update_done, 0);
        i_vert_sync = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
